load_store_unit: RTL
====================

# load_store_unit

Sequencing data-memory access stage for the RISC-V core. It sits directly downstream of the ALU address computation and upstream of register-file writeback. It takes one load/store request at a time, performs byte-lane alignment and sign/zero extension, and runs a valid/ready handshake to a data memory with variable latency. Results and faults return to the core as a single-cycle completion pulse.

## Interface
- TIMEOUT_CYCLES, 64: maximum cycles spent in WAIT before a timeout fault. Used only with the timeout feature; must be ≥ 2.
- i_clk  input  1  clock, rising edge
- i_arst  input  1  reset, asynchronous, active-high
- i_req  input  1  request valid from core
- o_reqReady  output  1  unit can accept a request (state IDLE)
- i_isStore  input  1  1 = store, 0 = load
- i_funct3  input  3  RV32I width/sign code
- i_address  input  32  byte address (rs1 + imm)
- i_storeData  input  32  rs2 value
- o_memValid  output  1  memory request valid
- i_memReady  input  1  memory accepts request
- o_memAddress  output  32  word-aligned address, i_address with [1:0] forced to 00
- o_memWrite  output  1  1 = write
- o_memByteEnable  output  4  active byte lanes
- o_memWriteData  output  32  lane-replicated store data
- i_memRespValid  input  1  load data valid
- i_memReadData  input  32  raw read word
- o_done  output  1  one-cycle completion pulse
- o_loadData  output  32  extended load result; valid with o_done on loads, 0 otherwise
- o_fault  output  1  with o_done: request failed, no writeback
- o_faultCause  output  2  00 none, 01 misaligned, 10 illegal funct3, 11 timeout

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - o_reqReady = 1.
  - On i_req, capture all request inputs.
  - Fault check → DONE with fault; otherwise → REQ.
- Faults:
  - Misaligned: halfword with address[0] = 1, or word with address[1:0] ≠ 00.
  - Illegal funct3: loads allow only 000/001/010/100/101; stores allow only 000/001/010.
  - Misaligned takes priority over illegal funct3.
  - A faulting request never asserts o_memValid.
- REQ:
  - o_memValid held at 1 with stable address, write, byte-enable and data until i_memReady.
  - On acceptance: store → DONE; load → WAIT.
- WAIT: on i_memRespValid, capture the extended read data → DONE.
- DONE: o_done = 1 for exactly one cycle → IDLE.
- Byte enables:
  - sb: 0001 << addr[1:0].
  - sh: 0011 << addr[1:0].
  - sw: 1111.
- Store data: sb replicates byte [7:0] ×4; sh replicates half [15:0] ×2; sw passes through.
- Load data: shift read word right by 8·addr[1:0]. lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.
- i_memRespValid outside WAIT is ignored. i_req outside IDLE is ignored.

## Timing
- All outputs reset to 0; state resets to IDLE. o_reqReady becomes 1 once out of reset.
- Reset mid-operation aborts immediately: no o_done, and a later stray response is ignored.
- Load, zero-wait memory: request accepted at cycle 0, REQ at 1, response at 2 (earliest), o_done at 3.
- Store, zero-wait memory: request accepted at cycle 0, REQ/accept at 1, o_done at 2.
- Faulting request: accepted at cycle 0, o_done + o_fault at 1.
- Back-to-back: the next request is accepted in the cycle after o_done. Throughput is at most one access per 3 cycles.
- o_memValid is never deasserted before i_memReady.

## Configuration
- LSU_TIMEOUT_EN defined:
  - A counter runs in WAIT.
  - After TIMEOUT_CYCLES cycles without i_memRespValid → DONE with cause 11, o_loadData = 0.
  - The counter clears on every entry to WAIT.
- LSU_TIMEOUT_EN undefined:
  - No counter logic; WAIT lasts indefinitely.
  - Cause 11 never occurs.

## Structure
- Package lsu_pkg holds:
  - state enum (IDLE/REQ/WAIT/DONE);
  - funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW);
  - fault-cause enum;
  - the TIMEOUT_CYCLES default.
- Sub-module lsu_align: purely combinational lane logic, i.e. byte enables, store replication, load shift/extension, misaligned/illegal detection.
- The FSM and registers remain in load_store_unit.

## Test plan
- lw 0x100, memory returns 0xDEADBEEF after 2 wait cycles → o_done one cycle after response, o_loadData = 0xDEADBEEF, o_fault = 0.
- lb 0x103, read word 0x80123456 → o_loadData = 0xFFFFFF80; lbu same → 0x00000080; lhu 0x102 → 0x00008012.
- sh 0x206 data 0x0000ABCD, i_memReady low 3 cycles → o_memValid stable 4 cycles, address 0x204, byte enable 1100, write data 0xABCDABCD, o_done 1 cycle after accept.
- lw 0x101 → o_done + o_fault next cycle, cause 01, o_memValid never asserted; store funct3 = 011 → cause 10.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES = 8: load with no response → o_done with cause 11 after 8 WAIT cycles; a late response is ignored.
- Assert i_arst while in WAIT, then pulse i_memRespValid → no o_done, outputs 0, next request completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and constants for the load/store unit
// Contents: FSM state enum, RV32I load/store funct3 codes, fault-cause enum,
// default WAIT timeout length.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } lsu_state_t;

    typedef enum logic [1:0] {
        FAULT_NONE       = 2'b00,
        FAULT_MISALIGNED = 2'b01,
        FAULT_ILLEGAL    = 2'b10,
        FAULT_TIMEOUT    = 2'b11
    } fault_cause_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam int TIMEOUT_CYCLES_DEFAULT = 64;

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - core-side and memory-side signals of the load/store unit
// Modports: slave = the load/store unit, master = the surrounding core/memory.
// Core side: i_req, o_reqReady, i_isStore, i_funct3, i_address, i_storeData,
//            o_done, o_loadData, o_fault, o_faultCause.
// Memory side: o_memValid, i_memReady, o_memAddress, o_memWrite, o_memByteEnable,
//              o_memWriteData, i_memRespValid, i_memReadData.
interface load_store_unit_if;

    logic        i_req;
    logic        o_reqReady;
    logic        i_isStore;
    logic [2:0]  i_funct3;
    logic [31:0] i_address;
    logic [31:0] i_storeData;

    logic        o_memValid;
    logic        i_memReady;
    logic [31:0] o_memAddress;
    logic        o_memWrite;
    logic [3:0]  o_memByteEnable;
    logic [31:0] o_memWriteData;
    logic        i_memRespValid;
    logic [31:0] i_memReadData;

    logic        o_done;
    logic [31:0] o_loadData;
    logic        o_fault;
    logic [1:0]  o_faultCause;

    modport slave (
        input  i_req, i_isStore, i_funct3, i_address, i_storeData,
        input  i_memReady, i_memRespValid, i_memReadData,
        output o_reqReady, o_memValid, o_memAddress, o_memWrite,
        output o_memByteEnable, o_memWriteData,
        output o_done, o_loadData, o_fault, o_faultCause
    );

    modport master (
        output i_req, i_isStore, i_funct3, i_address, i_storeData,
        output i_memReady, i_memRespValid, i_memReadData,
        input  o_reqReady, o_memValid, o_memAddress, o_memWrite,
        input  o_memByteEnable, o_memWriteData,
        input  o_done, o_loadData, o_fault, o_faultCause
    );

endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational byte-lane logic for loads and stores
// Inputs:  is_store, funct3, offset (address[1:0]), store_data, read_data.
// Outputs: byte_enable, write_data (lane-replicated), load_data (shifted and
//          extended), misaligned, illegal (funct3 not valid for the access type).
module lsu_align
    import lsu_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] read_data,
    output logic [3:0]  byte_enable,
    output logic [31:0] write_data,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        illegal
);

    logic [31:0] shifted;

    // funct3[1:0] is the access width: 00 byte, 01 half, 10 word, 11 unused.
    always_comb begin
        byte_enable = 4'b0000;
        write_data  = '0;
        misaligned  = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                byte_enable = 4'b0001 << offset;
                write_data  = {4{store_data[7:0]}};
            end
            2'b01: begin
                byte_enable = 4'b0011 << offset;
                write_data  = {2{store_data[15:0]}};
                misaligned  = offset[0];
            end
            2'b10: begin
                byte_enable = 4'b1111;
                write_data  = store_data;
                misaligned  = |offset;
            end
            default: ;
        endcase
    end

    always_comb begin
        if (is_store) begin
            illegal = !(funct3 inside {SB, SH, SW});
        end else begin
            illegal = !(funct3 inside {LB, LH, LW, LBU, LHU});
        end
    end

    assign shifted = read_data >> {offset, 3'b000};

    always_comb begin
        load_data = '0;
        case (funct3)
            LB:      load_data = {{24{shifted[7]}}, shifted[7:0]};
            LH:      load_data = {{16{shifted[15]}}, shifted[15:0]};
            LW:      load_data = shifted;
            LBU:     load_data = {24'h0, shifted[7:0]};
            LHU:     load_data = {16'h0, shifted[15:0]};
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - sequencing data-memory access stage (IDLE/REQ/WAIT/DONE)
// Ports: i_clk, i_arst (async, active-high), bus (load_store_unit_if.slave).
// Optional feature macro LSU_TIMEOUT_EN: adds a WAIT-state counter that ends a
// load with fault cause 11 after TIMEOUT_CYCLES cycles without a response.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
)
(
    input  logic              i_clk,
    input  logic              i_arst,
    load_store_unit_if.slave  bus
);

    lsu_state_t   state, state_nxt;
    logic         alive_q;
    logic         is_store_q;
    logic [2:0]   funct3_q;
    logic [31:0]  addr_q;
    logic [31:0]  store_data_q;
    logic [31:0]  load_q;
    logic         fault_q;
    fault_cause_t cause_q;

    logic         in_idle, in_req, in_wait, in_done, accept;
    logic         sel_store;
    logic [2:0]   sel_funct3;
    logic [1:0]   sel_offset;
    logic [31:0]  sel_data;
    logic [3:0]   lane_be;
    logic [31:0]  lane_wdata, lane_ldata;
    logic         misaligned, illegal, timeout_hit;

    assign in_idle = (state == IDLE);
    assign in_req  = (state == REQ);
    assign in_wait = (state == WAIT);
    assign in_done = (state == DONE);

    // alive_q keeps o_reqReady low while reset is held and for the first edge after.
    assign accept = in_idle && alive_q && bus.i_req;

    // In IDLE the lane logic checks the incoming request for faults; afterwards it
    // works from the captured copy so memory-side outputs stay stable in REQ.
    assign sel_store  = in_idle ? bus.i_isStore      : is_store_q;
    assign sel_funct3 = in_idle ? bus.i_funct3       : funct3_q;
    assign sel_offset = in_idle ? bus.i_address[1:0] : addr_q[1:0];
    assign sel_data   = in_idle ? bus.i_storeData    : store_data_q;

    lsu_align u_align (
        .is_store    (sel_store),
        .funct3      (sel_funct3),
        .offset      (sel_offset),
        .store_data  (sel_data),
        .read_data   (bus.i_memReadData),
        .byte_enable (lane_be),
        .write_data  (lane_wdata),
        .load_data   (lane_ldata),
        .misaligned  (misaligned),
        .illegal     (illegal)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] wait_cnt;

    // Held at zero outside WAIT, so every entry to WAIT starts a fresh count.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            wait_cnt <= '0;
        end else if (in_wait) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // A response in the final cycle still wins over the timeout.
    assign timeout_hit = in_wait && !bus.i_memRespValid &&
                         (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state   <= IDLE;
            alive_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            alive_q <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (misaligned || illegal) ? DONE : REQ;
            REQ:  if (bus.i_memReady) state_nxt = is_store_q ? DONE : WAIT;
            WAIT: if (bus.i_memRespValid || timeout_hit) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            is_store_q   <= 1'b0;
            funct3_q     <= '0;
            addr_q       <= '0;
            store_data_q <= '0;
            load_q       <= '0;
            fault_q      <= 1'b0;
            cause_q      <= FAULT_NONE;
        end else if (accept) begin
            is_store_q   <= bus.i_isStore;
            funct3_q     <= bus.i_funct3;
            addr_q       <= bus.i_address;
            store_data_q <= bus.i_storeData;
            load_q       <= '0;
            fault_q      <= misaligned || illegal;
            cause_q      <= misaligned ? FAULT_MISALIGNED :
                            illegal    ? FAULT_ILLEGAL    : FAULT_NONE;
        end else if (in_wait && bus.i_memRespValid) begin
            load_q <= lane_ldata;
        end else if (timeout_hit) begin
            fault_q <= 1'b1;
            cause_q <= FAULT_TIMEOUT;
        end
    end

    assign bus.o_reqReady      = in_idle && alive_q;
    assign bus.o_memValid      = in_req;
    assign bus.o_memAddress    = in_req ? {addr_q[31:2], 2'b00} : '0;
    assign bus.o_memWrite      = in_req && is_store_q;
    assign bus.o_memByteEnable = in_req ? lane_be : 4'b0000;
    assign bus.o_memWriteData  = in_req ? lane_wdata : '0;

    assign bus.o_done       = in_done;
    assign bus.o_fault      = in_done && fault_q;
    assign bus.o_faultCause = in_done ? cause_q : FAULT_NONE;
    assign bus.o_loadData   = (in_done && !is_store_q) ? load_q : '0;

endmodule
